// File: rtl/aes_pkg.sv
// Shared AES types and GF(2^8) helpers for the cipher datapaths.
// Multipliers reduce modulo x^8+x^4+x^3+x+1.
package aes_pkg;

  typedef logic [127:0] state_t;
  typedef logic [31:0]  col_t;

  localparam int NUM_COLS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MIX  = 2'd1,
    DONE = 2'd2
  } imc_state_e;

  function automatic logic [7:0] gf_mul2(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul9(input logic [7:0] x);
    return gf_mul2(gf_mul2(gf_mul2(x))) ^ x;
  endfunction

  function automatic logic [7:0] gf_mulb(input logic [7:0] x);
    return gf_mul2(gf_mul2(gf_mul2(x))) ^ gf_mul2(x) ^ x;
  endfunction

  function automatic logic [7:0] gf_muld(input logic [7:0] x);
    return gf_mul2(gf_mul2(gf_mul2(x))) ^ gf_mul2(gf_mul2(x)) ^ x;
  endfunction

  function automatic logic [7:0] gf_mule(input logic [7:0] x);
    logic [7:0] x2;
    logic [7:0] x4;
    x2 = gf_mul2(x);
    x4 = gf_mul2(x2);
    return gf_mul2(x4) ^ x4 ^ x2;
  endfunction

endpackage

// File: rtl/inv_col_mixer.sv
// Combinational InvMixColumns for one 32-bit column.
// Byte s0 is the column MSB.
module inv_col_mixer
  import aes_pkg::*;
(
  input  col_t col,
  output col_t mixed
);

  logic [7:0] s0, s1, s2, s3;

  assign s0 = col[31:24];
  assign s1 = col[23:16];
  assign s2 = col[15:8];
  assign s3 = col[7:0];

  assign mixed = {
    gf_mule(s0) ^ gf_mulb(s1) ^ gf_muld(s2) ^ gf_mul9(s3),
    gf_mul9(s0) ^ gf_mule(s1) ^ gf_mulb(s2) ^ gf_muld(s3),
    gf_muld(s0) ^ gf_mul9(s1) ^ gf_mule(s2) ^ gf_mulb(s3),
    gf_mulb(s0) ^ gf_muld(s1) ^ gf_mul9(s2) ^ gf_mule(s3)
  };

endmodule

// File: rtl/inv_mix_columns_seq.sv
// Sequential InvMixColumns: COLS_PER_CYCLE columns mixed per clock
// through shared mixers, valid/ready on both sides.
module inv_mix_columns_seq
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 ||
        COLS_PER_CYCLE == 4)) begin : g_bad_cols
    $error("COLS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam int NUM_PASSES = NUM_COLS / COLS_PER_CYCLE;
  localparam logic [1:0] LAST = 2'(NUM_PASSES - 1);

  imc_state_e state;
  logic [1:0] cnt;

  col_t [NUM_COLS-1:0] work;
  col_t [NUM_COLS-1:0] work_mix;
  col_t [COLS_PER_CYCLE-1:0] col_in;
  col_t [COLS_PER_CYCLE-1:0] col_out;
  logic [COLS_PER_CYCLE-1:0][1:0] sel;

  for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_mix
    assign sel[k] = 2'(int'(cnt) * COLS_PER_CYCLE + k);
    assign col_in[k] = work[sel[k]];

    inv_col_mixer u_mix (
      .col   (col_in[k]),
      .mixed (col_out[k])
    );
  end

  // Only the columns of the current pass are replaced.
  always_comb begin
    work_mix = work;
    for (int k = 0; k < COLS_PER_CYCLE; k++) begin
      work_mix[sel[k]] = col_out[k];
    end
  end

  assign in_ready  = (state == IDLE) ||
                     (state == DONE && out_ready);
  assign out_valid = (state == DONE);
  assign busy      = (state == MIX);
  assign out_state = work;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
      cnt   <= 2'd0;
      work  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            work  <= in_state;
            cnt   <= 2'd0;
            state <= MIX;
          end
        end
        MIX: begin
          work <= work_mix;
          cnt  <= cnt + 2'd1;
          if (cnt == LAST) state <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            if (in_valid) begin
              work  <= in_state;
              cnt   <= 2'd0;
              state <= MIX;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
